// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between a datapath controller and seq_alu.
//
// Handshake: the master raises start with op/a/b valid; the request is taken
// on the first rising edge where the ALU is idle (busy=0, done=0). From that
// edge busy is high until the done cycle; done is a one-cycle pulse and
// result/div_by_zero/illegal_op are valid from that cycle and hold until the
// next request is taken. start is ignored at every other edge, and operands
// may change freely once the request has been taken.
//
// Signals:
//   start, op[3:0], a[W-1:0], b[W-1:0]       master -> slave
//   busy, done, result[2W-1:0],
//   div_by_zero, illegal_op                   slave -> master
//   fsm_state[2:0]                            slave -> master, debug view of the FSM

interface seq_alu_if #(
  parameter int W = 32
);
  logic           start;
  logic [3:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_by_zero;
  logic           illegal_op;
  logic [2:0]     fsm_state;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero, illegal_op, fsm_state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero, illegal_op, fsm_state
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the datapath. Single-cycle ops complete in one
// cycle; MUL is an iterative radix-4 Booth multiplier (W/2 steps); DIV is an
// iterative non-restoring signed divider (W steps plus one fix-up cycle).
// result feeds the Z register pair: result[2W-1:W] -> ZHI, result[W-1:0] -> ZLO.
//
// Ports:
//   clock  in  rising-edge clock
//   clear  in  synchronous active-high reset
//   bus    seq_alu_if.slave: start/op/a/b in; busy/done/result/div_by_zero/
//          illegal_op/fsm_state out
//
// Op encoding: 0 AND, 1 OR, 2 NEG, 3 NOT, 4 ADD, 5 SUB, 6 MUL, 7 DIV,
//              8 SHR, 9 SHRA, 10 SHL, 11 ROR, 12 ROL, 13-15 illegal.

module seq_alu #(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input logic     clock,
  input logic     clear,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NEG  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SHRA = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_q;
  logic           busy_q;
  logic           done_q;
  logic [2*W-1:0] result_q;
  logic           dbz_q;
  logic           ill_q;
  logic [CW-1:0]  cnt_q;

  // Booth datapath: mcand_q is sign-extended a pre-shifted by 2 per step,
  // mplier_q is b consumed two bits per step, prev_q is the bit below them.
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic           prev_q;
  logic [2*W-1:0] acc_q;

  // Divider datapath: dq_q shifts dividend bits out of the top and quotient
  // bits in at the bottom; rem_q is the signed partial remainder.
  logic [W-1:0]   dq_q;
  logic [W+1:0]   rem_q;
  logic [W-1:0]   dvs_q;
  logic           neg_q_q;
  logic           neg_r_q;

  // ---------------- single-cycle ops ----------------
  logic [SHW-1:0] amt;
  logic [W-1:0]   single_val;
  logic           single_ill;
  logic [2*W-1:0] ror_t;
  logic [2*W-1:0] rol_t;

  assign amt = bus.b[SHW-1:0];

  always_comb begin
    single_val = '0;
    single_ill = 1'b0;
    ror_t      = {bus.a, bus.a} >> amt;
    rol_t      = {bus.a, bus.a} << amt;
    case (bus.op)
      OP_AND:  single_val = bus.a & bus.b;
      OP_OR:   single_val = bus.a | bus.b;
      OP_NEG:  single_val = -bus.a;
      OP_NOT:  single_val = ~bus.a;
      OP_ADD:  single_val = bus.a + bus.b;
      OP_SUB:  single_val = bus.a - bus.b;
      OP_SHR:  single_val = bus.a >> amt;
      OP_SHRA: single_val = $signed(bus.a) >>> amt;
      OP_SHL:  single_val = bus.a << amt;
      OP_ROR:  single_val = ror_t[W-1:0];
      OP_ROL:  single_val = rol_t[2*W-1:W];
      OP_MUL, OP_DIV: single_val = '0;
      default: single_ill = 1'b1;
    endcase
  end

  // ---------------- Booth step ----------------
  logic [2:0]     triplet;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] acc_next;

  assign triplet = {mplier_q[1:0], prev_q};

  always_comb begin
    pp = '0;
    case (triplet)
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = {mcand_q[2*W-2:0], 1'b0};
      3'b100:         pp = -{mcand_q[2*W-2:0], 1'b0};
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  assign acc_next = acc_q + pp;

  // ---------------- divider step and fix-up ----------------
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W+1:0]   rem_sh;
  logic [W+1:0]   rem_new;
  logic [W+1:0]   rem_fix;
  logic [W-1:0]   q_final;
  logic [W-1:0]   r_final;

  // Magnitudes as unsigned W-bit values; |MIN| = 2^(W-1) still fits.
  assign a_mag = bus.a[W-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[W-1] ? -bus.b : bus.b;

  // Non-restoring: subtract the divisor while the remainder is non-negative,
  // add it back in the next step when it went negative.
  assign rem_sh  = {rem_q[W:0], dq_q[W-1]};
  assign rem_new = rem_q[W+1] ? (rem_sh + {2'b00, dvs_q})
                              : (rem_sh - {2'b00, dvs_q});

  // Final restore leaves 0 <= rem < |b|; then the signs are applied.
  assign rem_fix = rem_q[W+1] ? (rem_q + {2'b00, dvs_q}) : rem_q;
  assign q_final = neg_q_q ? -dq_q : dq_q;
  assign r_final = neg_r_q ? -rem_fix[W-1:0] : rem_fix[W-1:0];

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prev_q   <= 1'b0;
      acc_q    <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dbz_q <= 1'b0;
            ill_q <= 1'b0;
            cnt_q <= '0;
            if (bus.op == OP_MUL) begin
              mcand_q  <= {{W{bus.a[W-1]}}, bus.a};
              mplier_q <= bus.b;
              prev_q   <= 1'b0;
              acc_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else if (bus.op == OP_DIV && bus.b != '0) begin
              dq_q    <= a_mag;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              neg_q_q <= bus.a[W-1] ^ bus.b[W-1];
              neg_r_q <= bus.a[W-1];
              busy_q  <= 1'b1;
              state_q <= S_DIV;
            end else if (bus.op == OP_DIV) begin
              result_q <= {bus.a, {W{1'b1}}};
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              result_q <= {{W{1'b0}}, single_val};
              ill_q    <= single_ill;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end

        S_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= {mcand_q[2*W-3:0], 2'b00};
          mplier_q <= {2'b00, mplier_q[W-1:2]};
          prev_q   <= mplier_q[1];
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(W/2 - 1)) begin
            result_q <= acc_next;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
        end

        S_DIV: begin
          rem_q <= rem_new;
          dq_q  <= {dq_q[W-2:0], ~rem_new[W+1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          result_q <= {r_final, q_final};
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu (W=32) against a
// behavioural model built on 64-bit signed arithmetic.

module tb_seq_alu;

  localparam int W = 32;

  logic clock;
  logic clear;

  seq_alu_if #(.W(W)) bus ();

  seq_alu #(.W(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [63:0] res,
                                output logic dbz, output logic ill, output int lat);
    longint sa, sb, p, q, r;
    logic [W-1:0] v;
    int amt;
    sa  = $signed(a);
    sb  = $signed(b);
    amt = int'(b[4:0]);
    res = '0;
    dbz = 1'b0;
    ill = 1'b0;
    lat = 1;
    v   = '0;
    case (op)
      4'd0: v = a & b;
      4'd1: v = a | b;
      4'd2: v = W'(0 - sa);
      4'd3: v = ~a;
      4'd4: v = W'(sa + sb);
      4'd5: v = W'(sa - sb);
      4'd8: v = W'(longint'({32'b0, a}) / (64'sd1 << amt));
      4'd9: v = W'(sa >>> amt);
      4'd10: v = W'(longint'({32'b0, a}) * (64'sd1 << amt));
      4'd11: begin
        v = a;
        for (int k = 0; k < amt; k++) v = {v[0], v[W-1:1]};
      end
      4'd12: begin
        v = a;
        for (int k = 0; k < amt; k++) v = {v[W-2:0], v[W-1]};
      end
      default: ;
    endcase
    res = {32'b0, v};
    if (op == 4'd6) begin
      p   = sa * sb;
      res = p;
      lat = W/2 + 1;
    end else if (op == 4'd7) begin
      if (b == '0) begin
        res = {a, 32'hFFFF_FFFF};
        dbz = 1'b1;
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
        lat = W + 2;
      end
    end else if (op >= 4'd13) begin
      res = '0;
      ill = 1'b1;
    end
  endfunction

  // ---------------- driver ----------------
  // Called in an idle cycle, #1 after a rising edge. Returns #1 after the
  // edge that follows the done cycle, i.e. in the next idle cycle.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] exp_res;
    logic exp_dbz, exp_ill;
    int exp_lat, cyc;
    logic busy_ok;
    model(op, a, b, exp_res, exp_dbz, exp_ill, exp_lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.op    = 4'($urandom_range(0, 15));
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " busy_while_running"}, 64'(busy_ok), 64'(1));
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    check({tag, " illegal_op"}, 64'(bus.illegal_op), 64'(exp_ill));
    @(posedge clock); #1;
    check({tag, " done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, " result_hold"}, bus.result, exp_res);
    check({tag, " flags_hold"}, {62'b0, bus.div_by_zero, bus.illegal_op},
          {62'b0, exp_dbz, exp_ill});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h8000_0000;
      1: pick = 32'hFFFF_FFFF;
      2: pick = W'($urandom_range(0, 40));
      3: pick = '0;
      default: pick = $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clear     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset result", bus.result, 64'(0));
    check("reset flags", {62'b0, bus.div_by_zero, bus.illegal_op}, 64'(0));
    clear = 1'b0;
    @(posedge clock); #1;

    // Directed cases
    run_op("and", 4'd0, 32'hF0F0_F0F0, 32'h0FF0_FFFF);
    check("and literal", bus.result, 64'h0000_0000_00F0_F0F0);
    run_op("mul_neg7x6", 4'd6, 32'hFFFF_FFF9, 32'd6);
    check("mul literal", bus.result, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("mul_minxmin", 4'd6, 32'h8000_0000, 32'h8000_0000);
    check("mul_min literal", bus.result, 64'h4000_0000_0000_0000);
    run_op("div_m17_5", 4'd7, 32'hFFFF_FFEF, 32'd5);
    check("div literal", bus.result, 64'hFFFF_FFFE_FFFF_FFFD);
    run_op("div_min_m1", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min literal", bus.result, 64'h0000_0000_8000_0000);
    run_op("div_by_0", 4'd7, 32'h0000_1234, 32'd0);
    check("dbz literal", bus.result, 64'h0000_1234_FFFF_FFFF);
    run_op("add_after_dbz", 4'd4, 32'd10, 32'd20);
    run_op("ror", 4'd11, 32'h0000_0001, 32'h0000_0021);
    check("ror literal", bus.result, 64'h0000_0000_8000_0000);
    run_op("shra", 4'd9, 32'h8000_0000, 32'd4);
    check("shra literal", bus.result, 64'h0000_0000_F800_0000);
    run_op("illegal14", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("neg_min", 4'd2, 32'h8000_0000, 32'd0);
    run_op("rol0", 4'd12, 32'hDEAD_BEEF, 32'h0000_0020);
    run_op("sub_wrap", 4'd5, 32'd0, 32'd1);
    run_op("div_7_m2", 4'd7, 32'd7, 32'hFFFF_FFFE);

    // Clear during a MUL, with an ignored start pulse in between
    bus.start = 1'b1;
    bus.op    = 4'd6;
    bus.a     = 32'd1234;
    bus.b     = 32'd5678;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    bus.start = 1'b1;
    bus.op    = 4'd4;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("abort busy_after_ignored_start", 64'(bus.busy), 64'(1));
    check("abort no_done_yet", 64'(bus.done), 64'(0));
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort done", 64'(bus.done), 64'(0));
    check("abort result", bus.result, 64'(0));
    run_op("add_3_4", 4'd4, 32'd3, 32'd4);
    check("add literal", bus.result, 64'd7);

    // Randomized
    for (int i = 0; i < 60; i++) begin
      logic [3:0] rop;
      logic [W-1:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = pick();
      rb  = pick();
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
